// File: rtl/scope_3ph_trig_ctrl.sv
// scope_3ph_trig_ctrl: three-phase scope capture FSM with pre-trigger history and level/edge or forced trigger.
module scope_3ph_trig_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] phase_a,
  input  logic signed [DATA_W-1:0] phase_b,
  input  logic signed [DATA_W-1:0] phase_c,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic [1:0]               trig_src,
  input  logic                     trig_edge,
  input  logic [ADDR_W-1:0]        pretrig_len,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  logic [1:0]               src_q;
  logic                     edge_q;
  logic signed [DATA_W-1:0] lvl_q;
  logic signed [DATA_W-1:0] prev_q;
  logic signed [DATA_W-1:0] cur;
  logic                     prev_v;
  logic [ADDR_W-1:0]        pre_q;
  logic [ADDR_W-1:0]        cnt;
  logic [ADDR_W-1:0]        cnt_nx;
  logic                     hit;
  always_comb begin
    busy   = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    wr_en  = busy && sample_valid && !abort && !ARESET;
    cur    = src_q == 2'd0 ? phase_a : src_q == 2'd1 ? phase_b : phase_c;
    cnt_nx = cnt + 1'b1;
    hit    = (src_q == 2'd3) || (prev_v && (edge_q ? (prev_q > lvl_q && cur <= lvl_q)
                                                   : (prev_q < lvl_q && cur >= lvl_q)));
  end
  // ~pre_q equals DEPTH-1-pretrig: the number of post-trigger writes after the trigger sample
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= S_IDLE;
      wr_addr   <= '0;
      trig_addr <= '0;
      done      <= 1'b0;
      prev_v    <= 1'b0;
      cnt       <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else if (arm && !busy) begin
      src_q   <= trig_src;
      edge_q  <= trig_edge;
      lvl_q   <= trig_level;
      pre_q   <= pretrig_len;
      done    <= 1'b0;
      wr_addr <= '0;
      prev_v  <= 1'b0;
      cnt     <= '0;
      state   <= pretrig_len == '0 ? S_WAIT : S_PRE;
    end else if (wr_en) begin
      wr_addr <= wr_addr + 1'b1;
      prev_q  <= cur;
      prev_v  <= 1'b1;
      cnt     <= cnt_nx;
      if (state == S_PRE && cnt_nx == pre_q) state <= S_WAIT;
      if (state == S_WAIT && hit) begin
        trig_addr <= wr_addr;
        cnt       <= '0;
        state     <= &pre_q ? S_DONE : S_POST;
        done      <= &pre_q;
      end
      if (state == S_POST && cnt_nx == ~pre_q) begin
        state <= S_DONE;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scope_3ph_trig_ctrl.sv
// tb_scope_3ph_trig_ctrl: directed self-checking bench for scope_3ph_trig_ctrl at ADDR_W=4.
module tb_scope_3ph_trig_ctrl;
  logic               tb_ACLK = 1'b0;
  logic               ARESET, arm, abort, sample_valid, trig_edge;
  logic signed [15:0] phase_a, phase_b, phase_c, trig_level;
  logic [1:0]         trig_src;
  logic [3:0]         pretrig_len;
  logic               wr_en, busy, done;
  logic [3:0]         wr_addr, trig_addr;
  logic [2:0]         state;
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr;

  scope_3ph_trig_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET), .arm(arm), .abort(abort), .sample_valid(sample_valid),
    .phase_a(phase_a), .phase_b(phase_b), .phase_c(phase_c), .trig_level(trig_level),
    .trig_src(trig_src), .trig_edge(trig_edge), .pretrig_len(pretrig_len), .wr_en(wr_en),
    .wr_addr(wr_addr), .trig_addr(trig_addr), .busy(busy), .done(done), .state(state)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic samp(input int a, input int c);
    sample_valid = 1'b1;
    phase_a = 16'(a);
    phase_c = 16'(c);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] src, input logic edg, input int lvl, input logic [3:0] pre);
    trig_src = src;
    trig_edge = edg;
    trig_level = 16'(lvl);
    pretrig_len = pre;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1; arm = 1'b0; abort = 1'b0; sample_valid = 1'b0; trig_edge = 1'b0;
    phase_a = '0; phase_b = '0; phase_c = '0; trig_level = '0; trig_src = '0; pretrig_len = '0;
    tick(); tick();
    ARESET = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    sample_valid = 1'b1; #1;
    chk("idle_wr_en", wr_en, 0);
    sample_valid = 1'b0;

    // ramp on A from -8, rising through 0, pretrig 4
    do_arm(2'd0, 1'b0, 0, 4'd4);
    chk("arm_state_pre", state, 1);
    chk("arm_busy", busy, 1);
    for (int i = 0; i < 9; i++) begin
      samp(-8 + i, 0);
      if (i == 2) chk("ramp_still_pre", state, 1);
      if (i == 3) chk("ramp_wait", state, 2);
      if (i == 7) chk("ramp_no_trig_yet", state, 2);
    end
    chk("ramp_post", state, 3);
    chk("ramp_trig_addr", trig_addr, 8);
    for (int i = 0; i < 5; i++) samp(1, 0);
    do_arm(2'd1, 1'b1, 5, 4'd0);
    chk("arm_in_post_ignored", state, 3);
    chk("arm_in_post_addr", wr_addr, 14);
    for (int i = 0; i < 5; i++) samp(1, 0);
    chk("ramp_post_10", state, 3);
    sample_valid = 1'b1; #1;
    chk("post_wr_en", wr_en, 1);
    tick();
    sample_valid = 1'b0;
    chk("ramp_done_state", state, 4);
    chk("ramp_done", done, 1);
    chk("ramp_busy_fall", busy, 0);
    chk("ramp_wrap_addr", wr_addr, 4);
    sample_valid = 1'b1; #1;
    chk("done_wr_en", wr_en, 0);
    sample_valid = 1'b0;

    // crossing inside PRE is ignored; later crossing in WAIT triggers
    do_arm(2'd0, 1'b0, 0, 4'd4);
    chk("rearm_done_clear", done, 0);
    chk("rearm_addr", wr_addr, 0);
    samp(-1, 0); samp(0, 0); samp(1, 0); samp(2, 0);
    chk("pre_cross_ignored", state, 2);
    samp(3, 0); samp(-5, 0);
    chk("wait_no_cross", state, 2);
    samp(5, 0);
    chk("wait_cross_post", state, 3);
    chk("wait_cross_addr", trig_addr, 6);
    abort = 1'b1; sample_valid = 1'b1; #1;
    chk("abort_wr_en", wr_en, 0);
    tick();
    abort = 1'b0; sample_valid = 1'b0;
    chk("abort_idle", state, 0);
    chk("abort_done", done, 0);
    chk("abort_keep_trig", trig_addr, 6);
    chk("abort_addr_frozen", wr_addr, 7);

    // forced trigger, pretrig 0: full buffer after trigger
    do_arm(2'd3, 1'b0, 0, 4'd0);
    chk("forced_wait", state, 2);
    n_wr = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      sample_valid = 1'b1; #1;
      if (wr_en) n_wr++;
      tick();
      if (i == 0) chk("forced_trig_addr", trig_addr, 0);
    end
    sample_valid = 1'b0;
    chk("forced_writes", n_wr, 16);
    chk("forced_done", done, 1);
    chk("forced_state", state, 4);

    // falling edge on C at 100
    do_arm(2'd2, 1'b1, 100, 4'd0);
    samp(0, 200); samp(0, 150);
    chk("fall_no_trig", state, 2);
    samp(0, 100);
    chk("fall_trig", state, 3);
    chk("fall_trig_addr", trig_addr, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    do_arm(2'd2, 1'b1, 100, 4'd0);
    samp(0, 100); samp(0, 100); samp(0, 99);
    chk("fall_equal_no_trig", state, 2);

    // arm together with abort behaves as abort
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("arm_abort_wait", state, 0);
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("arm_abort_idle", state, 0);

    // reset while waiting overrides arm/abort
    do_arm(2'd0, 1'b0, 1000, 4'd0);
    samp(0, 0); samp(0, 0);
    ARESET = 1'b1; arm = 1'b1; sample_valid = 1'b1; #1;
    chk("rst_wr_en", wr_en, 0);
    tick();
    ARESET = 1'b0; arm = 1'b0; sample_valid = 1'b0;
    chk("rstw_state", state, 0);
    chk("rstw_wr_addr", wr_addr, 0);
    chk("rstw_trig_addr", trig_addr, 0);
    chk("rstw_busy", busy, 0);

    // maximum pretrig: trigger sample is the only post-trigger write
    do_arm(2'd3, 1'b0, 0, 4'd15);
    for (int i = 0; i < 15; i++) samp(i, 0);
    chk("max_pre_wait", state, 2);
    samp(0, 0);
    chk("max_pre_done", state, 4);
    chk("max_pre_trig_addr", trig_addr, 15);
    chk("max_pre_wrap", wr_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
